skinny_sbox_layer_ctrl: RTL and testbench

Sequencer that applies the masked Skinny-64 S-box layer to a full 64-bit shared state. It uses one shared, free-running, pipelined first-order HPC2 S-box instance, which sits outside this block and is reached through the sb_* ports. The block issues one nibble per cycle, supplies the S-box with fresh randomness every cycle, tracks in-flight nibbles with a valid/index pipeline, and reassembles the shared result. It sits between the round-function state register and the S-box datapath.

---
 rtl/skinny_mask_pkg.sv | 16 +
 rtl/skinny_sbox_layer_ctrl_if.sv | 42 ++++
 rtl/sbox_tag_pipe.sv | 44 ++++
 rtl/skinny_sbox_layer_ctrl.sv | 126 ++++++++++++
 tb/tb_skinny_sbox_layer_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/skinny_mask_pkg.sv
// Shared types and constants for the masked Skinny-64 S-box layer.
// Sizes match the first-order HPC2 S-box datapath.
package skinny_mask_pkg;

    localparam int SKINNY64_NIBBLES = 16;
    localparam int HPC2_D1_SBOX_LAT = 5;
    localparam int HPC2_D1_RND_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sbox_state_e;

endpackage

// File: rtl/skinny_sbox_layer_ctrl_if.sv
// Bus between the S-box layer sequencer and its environment:
// round-state handshake, PRNG feed and the external S-box port.
interface skinny_sbox_layer_ctrl_if #(
    parameter int NIBBLES = 16,
    parameter int RND_W   = 4
);
    logic                   start;
    logic [4*NIBBLES-1:0]   state_in_s0;
    logic [4*NIBBLES-1:0]   state_in_s1;
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES-1:0]   state_out_s0;
    logic [4*NIBBLES-1:0]   state_out_s1;
    logic [RND_W-1:0]       rnd_in;
    logic                   rnd_valid;
    logic                   rnd_ready;
    logic                   rnd_err;
    logic [3:0]             sb_x_s0;
    logic [3:0]             sb_x_s1;
    logic [RND_W-1:0]       sb_fresh;
    logic [3:0]             sb_y_s0;
    logic [3:0]             sb_y_s1;

    modport master (
        input  start, state_in_s0, state_in_s1,
        input  rnd_in, rnd_valid,
        input  sb_y_s0, sb_y_s1,
        output busy, done, state_out_s0, state_out_s1,
        output rnd_ready, rnd_err,
        output sb_x_s0, sb_x_s1, sb_fresh
    );

    modport slave (
        output start, state_in_s0, state_in_s1,
        output rnd_in, rnd_valid,
        output sb_y_s0, sb_y_s1,
        input  busy, done, state_out_s0, state_out_s1,
        input  rnd_ready, rnd_err,
        input  sb_x_s0, sb_x_s1, sb_fresh
    );

endinterface

// File: rtl/sbox_tag_pipe.sv
// Valid + nibble-index shift register that shadows the S-box pipeline.
// The tail marks which output nibble the S-box result belongs to.
module sbox_tag_pipe #(
    parameter int DEPTH = 5,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push_valid,
    input  logic [TAG_W-1:0] push_tag,
    output logic             tail_valid,
    output logic [TAG_W-1:0] tail_tag,
    output logic             any_valid,
    output logic             head_empty
);
    localparam logic [DEPTH-1:0] HEAD_MASK =
        DEPTH'((1 << (DEPTH - 1)) - 1);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q  <= {valid_q[DEPTH-2:0], push_valid};
            tag_q[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tail_valid = valid_q[DEPTH-1];
    assign tail_tag   = tag_q[DEPTH-1];
    assign any_valid  = |valid_q;
    // Empty after the next shift: only the tail may still be occupied.
    assign head_empty = ~|(valid_q & HEAD_MASK);

endmodule

// File: rtl/skinny_sbox_layer_ctrl.sv
// Sequences one shared 64-bit state through a single pipelined HPC2
// S-box, one nibble per cycle, and reassembles the shared result.
module skinny_sbox_layer_ctrl
    import skinny_mask_pkg::*;
#(
    parameter int NIBBLES  = SKINNY64_NIBBLES,
    parameter int SBOX_LAT = HPC2_D1_SBOX_LAT,
    parameter int RND_W    = HPC2_D1_RND_W
) (
    input  logic clk,
    input  logic rst_n,
    skinny_sbox_layer_ctrl_if.master bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int TW = $clog2(NIBBLES);
    localparam logic [TW-1:0] LAST = TW'(NIBBLES - 1);

    sbox_state_e   state;
    logic [W-1:0]  buf_s0;
    logic [W-1:0]  buf_s1;
    logic [TW-1:0] cnt;
    logic [TW-1:0] nxt;
    logic          accept;
    logic          push_valid;
    logic          tail_valid;
    logic [TW-1:0] tail_tag;
    logic          any_valid;
    logic          head_empty;
    logic [RND_W-1:0] fresh;

    assign accept     = (state == IDLE) && bus.start;
    assign push_valid = (state == ISSUE);
    assign nxt        = cnt + TW'(1);

    sbox_tag_pipe #(
        .DEPTH (SBOX_LAT),
        .TAG_W (TW)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (accept),
        .push_valid (push_valid),
        .push_tag   (cnt),
        .tail_valid (tail_valid),
        .tail_tag   (tail_tag),
        .any_valid  (any_valid),
        .head_empty (head_empty)
    );

    // Randomness passes straight through; it is never held here.
    assign fresh         = bus.rnd_in;
    assign bus.sb_fresh  = fresh;
    assign bus.rnd_ready = (state == ISSUE) || (state == DRAIN)
                         || any_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            buf_s0      <= '0;
            buf_s1      <= '0;
            cnt         <= '0;
            bus.sb_x_s0 <= '0;
            bus.sb_x_s1 <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        buf_s0      <= bus.state_in_s0;
                        buf_s1      <= bus.state_in_s1;
                        cnt         <= '0;
                        bus.sb_x_s0 <= bus.state_in_s0[3:0];
                        bus.sb_x_s1 <= bus.state_in_s1[3:0];
                        bus.busy    <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == LAST) begin
                        bus.sb_x_s0 <= '0;
                        bus.sb_x_s1 <= '0;
                        state       <= DRAIN;
                    end else begin
                        cnt         <= nxt;
                        bus.sb_x_s0 <= buf_s0[4*nxt +: 4];
                        bus.sb_x_s1 <= buf_s1[4*nxt +: 4];
                    end
                end
                DRAIN: begin
                    if (head_empty) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.state_out_s0 <= '0;
            bus.state_out_s1 <= '0;
        end else if (tail_valid) begin
            bus.state_out_s0[4*tail_tag +: 4] <= bus.sb_y_s0;
            bus.state_out_s1[4*tail_tag +: 4] <= bus.sb_y_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rnd_err <= 1'b0;
        end else if (accept) begin
            bus.rnd_err <= 1'b0;
        end else if (bus.rnd_ready && !bus.rnd_valid) begin
            bus.rnd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// Bench for the S-box layer sequencer with a behavioural masked
// S-box model and a scoreboard of unmasked expected results.
module tb_skinny_sbox_layer_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [63:0] sb_q[$];
    logic [7:0]  sp [5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    skinny_sbox_layer_ctrl_if #(.NIBBLES(16), .RND_W(4)) bus ();

    skinny_sbox_layer_ctrl #(
        .NIBBLES  (16),
        .SBOX_LAT (5),
        .RND_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [3:0] sb4(input logic [3:0] x);
        case (x)
            4'h0: sb4 = 4'hc;  4'h1: sb4 = 4'h6;
            4'h2: sb4 = 4'h9;  4'h3: sb4 = 4'h0;
            4'h4: sb4 = 4'h1;  4'h5: sb4 = 4'ha;
            4'h6: sb4 = 4'h2;  4'h7: sb4 = 4'hb;
            4'h8: sb4 = 4'h3;  4'h9: sb4 = 4'h8;
            4'ha: sb4 = 4'h5;  4'hb: sb4 = 4'hd;
            4'hc: sb4 = 4'h4;  4'hd: sb4 = 4'he;
            4'he: sb4 = 4'h7;  default: sb4 = 4'hf;
        endcase
    endfunction

    function automatic logic [63:0] sb64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sb4(x[4*i +: 4]);
        return r;
    endfunction

    // Masked S-box model, 5 register stages, remasked with Fresh.
    always @(posedge clk) begin
        sp[0] <= {sb4(bus.sb_x_s0 ^ bus.sb_x_s1) ^ bus.sb_fresh,
                  bus.sb_fresh};
        for (int i = 1; i < 5; i++) sp[i] <= sp[i-1];
    end
    assign bus.sb_y_s0 = sp[4][7:4];
    assign bus.sb_y_s1 = sp[4][3:0];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [63:0] s0, input logic [63:0] s1,
                          input int poke_a, input int poke_b,
                          input int drop_at, input int rst_at,
                          input bit full, output int lat,
                          output int ndone, output int t0);
        logic [63:0] exp;
        lat = -1;
        ndone = 0;
        @(negedge clk);
        t0 = cyc;
        if (rst_at < 0) sb_q.push_back(sb64(s0 ^ s1));
        bus.state_in_s0 = s0;
        bus.state_in_s1 = s1;
        bus.start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.rnd_in = 4'($urandom);
            bus.start = (k == poke_a) || (k == poke_b);
            bus.state_in_s0 = bus.start ? ~s0 : s0;
            bus.rnd_valid = (k != drop_at);
            rst_n = (k != rst_at);
            if (k == 1) chk("busy_start", bus.busy, 1);
            if (rst_at < 0 && k <= 16) begin
                chk("sbx0", bus.sb_x_s0, s0[4*(k-1) +: 4]);
                chk("sbx1", bus.sb_x_s1, s1[4*(k-1) +: 4]);
            end
            if (rst_at < 0 && k == 18)
                chk("sbx_drain", {bus.sb_x_s0, bus.sb_x_s1}, 0);
            if (k == rst_at + 1) begin
                chk("rst_busy", bus.busy, 0);
                chk("rst_out0", bus.state_out_s0, 0);
                chk("rst_out1", bus.state_out_s1, 0);
                chk("rst_sbx", {bus.sb_x_s0, bus.sb_x_s1}, 0);
            end
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = k;
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp = sb_q.pop_front();
                    chk("result", bus.state_out_s0 ^ bus.state_out_s1,
                        exp);
                    chk("busy_at_done", bus.busy, 0);
                end
            end
            if (!full && lat >= 0) break;
        end
        bus.start = 1'b0;
        bus.state_in_s0 = s0;
        bus.rnd_valid = 1'b1;
        rst_n = 1'b1;
        if (rst_at < 0) chk("latency", lat, 22);
    endtask

    initial begin
        logic [63:0] s0, s1, m;
        int lat, nd, t0, tprev;
        bus.start = 1'b0;
        bus.state_in_s0 = '0;
        bus.state_in_s1 = '0;
        bus.rnd_in = '0;
        bus.rnd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_out", bus.state_out_s0 | bus.state_out_s1, 0);
        chk("reset_ready", bus.rnd_ready, 0);
        chk("reset_sbx", {bus.sb_x_s0, bus.sb_x_s1}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_err", bus.rnd_err, 0);
        bus.rnd_valid = 1'b1;

        run_op(64'h0, 64'h0, -1, -1, -1, -1, 1'b0, lat, nd, t0);
        chk("zero_out", bus.state_out_s0 ^ bus.state_out_s1,
            64'hCCCCCCCCCCCCCCCC);

        m = {$urandom, $urandom};
        s0 = 64'hFEDCBA9876543210 ^ m;
        run_op(s0, m, -1, -1, -1, -1, 1'b0, lat, nd, t0);
        chk("fedc_out", bus.state_out_s0 ^ bus.state_out_s1,
            sb64(64'hFEDCBA9876543210));
        chk("share0_masked",
            bus.state_out_s0 != sb64(64'hFEDCBA9876543210), 1);
        chk("share1_masked",
            bus.state_out_s1 != sb64(64'hFEDCBA9876543210), 1);

        s1 = {$urandom, $urandom};
        run_op({$urandom, $urandom}, s1, -1, -1, 5, -1, 1'b0,
               lat, nd, t0);
        chk("rnd_err_sticky", bus.rnd_err, 1);
        run_op({$urandom, $urandom}, s1, -1, -1, -1, -1, 1'b0,
               lat, nd, t0);
        chk("rnd_err_clear", bus.rnd_err, 0);

        s0 = {$urandom, $urandom};
        run_op(s0, s1, 5, 20, -1, -1, 1'b1, lat, nd, t0);
        chk("one_done", nd, 1);
        chk("first_state", bus.state_out_s0 ^ bus.state_out_s1,
            sb64(s0 ^ s1));

        run_op({$urandom, $urandom}, s1, -1, -1, -1, 10, 1'b1,
               lat, nd, t0);
        chk("abort_no_done", nd, 0);
        chk("abort_out", bus.state_out_s0 | bus.state_out_s1, 0);
        run_op(64'h0123456789ABCDEF, s1, -1, -1, -1, -1, 1'b0,
               lat, nd, t0);
        chk("after_abort", bus.state_out_s0 ^ bus.state_out_s1,
            sb64(64'h0123456789ABCDEF ^ s1));

        tprev = -1;
        for (int r = 0; r < 100; r++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom},
                   -1, -1, -1, -1, 1'b0, lat, nd, t0);
            if (tprev >= 0) chk("period", t0 - tprev, 23);
            tprev = t0;
        end
        chk("queue_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
